// File: rtl/echo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : echo_pkg
//  Description : Shared widths, state encoding and saturation helper for the
//                echo loop blocks (processor and delay-buffer mixers).
//  Revision    : 1.0 - initial release
// ============================================================================
package echo_pkg;

    localparam int ECHO_SAMPLE_WIDTH = 16;
    localparam int ECHO_COEF_WIDTH   = 8;

    // Processor FSM encoding
    typedef logic [2:0] state_t;
    localparam state_t c_st_idle    = 3'd0;
    localparam state_t c_st_mul_wet = 3'd1;
    localparam state_t c_st_mul_fb  = 3'd2;
    localparam state_t c_st_sum     = 3'd3;
    localparam state_t c_st_out     = 3'd4;

    // Clamp a one-bit-wider sum back into the sample range
    function automatic logic signed [ECHO_SAMPLE_WIDTH-1:0] echo_saturate(
        input logic signed [ECHO_SAMPLE_WIDTH:0] value
    );
        logic signed [ECHO_SAMPLE_WIDTH-1:0] result;
        result = value[ECHO_SAMPLE_WIDTH-1:0];
        if (value[ECHO_SAMPLE_WIDTH] != value[ECHO_SAMPLE_WIDTH-1]) begin
            result = {value[ECHO_SAMPLE_WIDTH], {(ECHO_SAMPLE_WIDTH-1){~value[ECHO_SAMPLE_WIDTH]}}};
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/echo_feedback_processor_serial_signed_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : serial_signed_multiplier
//  Description : MSB-first shift-add multiplier, signed multiplicand times an
//                unsigned coefficient, one coefficient bit per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_signed_multiplier #(
    parameter int MCAND_WIDTH = 16,
    parameter int COEF_WIDTH  = 8
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     i_start,
    input  logic signed [MCAND_WIDTH-1:0]            i_multiplicand,
    input  logic        [COEF_WIDTH-1:0]             i_coef,
    output logic                                     o_done,
    output logic signed [MCAND_WIDTH+COEF_WIDTH:0]   o_product
);

    localparam int PROD_WIDTH = MCAND_WIDTH + COEF_WIDTH + 1;
    localparam int CNT_WIDTH  = $clog2(COEF_WIDTH + 1);

    logic signed [PROD_WIDTH-1:0]  r_acc;
    logic signed [MCAND_WIDTH-1:0] r_mcand;
    logic        [COEF_WIDTH-1:0]  r_coef;
    logic        [CNT_WIDTH-1:0]   r_remaining;
    logic                          r_busy;
    logic signed [PROD_WIDTH-1:0]  w_first_addend;
    logic signed [PROD_WIDTH-1:0]  w_step_addend;

    // Addends: the start cycle consumes the coefficient MSB straight from the inputs
    always_comb begin
        w_first_addend = '0;
        w_step_addend  = '0;
        if (i_coef[COEF_WIDTH-1]) begin
            w_first_addend = {{(COEF_WIDTH+1){i_multiplicand[MCAND_WIDTH-1]}}, i_multiplicand};
        end
        if (r_coef[COEF_WIDTH-1]) begin
            w_step_addend = {{(COEF_WIDTH+1){r_mcand[MCAND_WIDTH-1]}}, r_mcand};
        end
    end

    // Shift-add accumulator: start performs step one, busy performs the rest
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_mcand     <= '0;
            r_coef      <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
        end else if (i_start) begin
            r_acc       <= w_first_addend;
            r_mcand     <= i_multiplicand;
            r_coef      <= i_coef << 1;
            r_remaining <= CNT_WIDTH'(COEF_WIDTH - 1);
            r_busy      <= (COEF_WIDTH > 1);
        end else if (r_busy) begin
            r_acc       <= (r_acc <<< 1) + w_step_addend;
            r_coef      <= r_coef << 1;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == CNT_WIDTH'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    // o_done flags the cycle whose closing edge writes the final product
    assign o_done    = i_start ? (COEF_WIDTH == 1) : (r_busy && (r_remaining == CNT_WIDTH'(1)));
    assign o_product = r_acc;

endmodule
`default_nettype wire

// File: rtl/echo_feedback_processor.sv
`default_nettype none
// ============================================================================
//  Module      : echo_feedback_processor
//  Description : Takes a (current, delayed) sample pair, forms the wet output
//                and the feedback sample with two gains through one shared
//                serial multiplier, and returns both over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module echo_feedback_processor
    import echo_pkg::*;
#(
    parameter int SAMPLE_WIDTH = ECHO_SAMPLE_WIDTH,
    parameter int COEF_WIDTH   = ECHO_COEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic [SAMPLE_WIDTH-1:0] i_current,
    input  logic [SAMPLE_WIDTH-1:0] i_buffer,
    input  logic [COEF_WIDTH-1:0]   i_wet_gain,
    input  logic [COEF_WIDTH-1:0]   i_feedback_gain,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [SAMPLE_WIDTH-1:0] o_current,
    output logic [SAMPLE_WIDTH-1:0] o_feedback
);

    localparam int PROD_WIDTH = SAMPLE_WIDTH + COEF_WIDTH + 1;

    state_t                         r_state;
    state_t                         w_next_state;
    logic                           r_first;
    logic signed [SAMPLE_WIDTH-1:0] r_current;
    logic signed [SAMPLE_WIDTH-1:0] r_buffer;
    logic        [COEF_WIDTH-1:0]   r_wet_gain;
    logic        [COEF_WIDTH-1:0]   r_fb_gain;
    logic signed [SAMPLE_WIDTH:0]   r_wet_scaled;
    logic                           r_in_ready;
    logic                           r_out_valid;
    logic        [SAMPLE_WIDTH-1:0] r_out_current;
    logic        [SAMPLE_WIDTH-1:0] r_out_feedback;
    logic                           w_accept;
    logic                           w_mul_start;
    logic                           w_mul_done;
    logic        [COEF_WIDTH-1:0]   w_mul_coef;
    logic signed [PROD_WIDTH-1:0]   w_mul_product;
    logic        [SAMPLE_WIDTH:0]   w_wet_sum;
    logic        [SAMPLE_WIDTH:0]   w_fb_sum;
    logic        [SAMPLE_WIDTH-1:0] w_wet_sat;
    logic        [SAMPLE_WIDTH-1:0] w_fb_sat;
    logic                           w_unused_product_bits;

    assign w_accept = i_valid && r_in_ready;

    // State register; r_first marks the first cycle spent in a new state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_first <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_first <= (w_next_state != r_state);
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:    if (w_accept)   w_next_state = c_st_mul_wet;
            c_st_mul_wet: if (w_mul_done) w_next_state = c_st_mul_fb;
            c_st_mul_fb:  if (w_mul_done) w_next_state = c_st_sum;
            c_st_sum:                     w_next_state = c_st_out;
            c_st_out:     if (o_ready)    w_next_state = c_st_idle;
            default:                      w_next_state = c_st_idle;
        endcase
    end

    // Multiplier control: kick it off on entry to each multiply state
    always_comb begin
        w_mul_start = 1'b0;
        w_mul_coef  = r_wet_gain;
        if ((r_state == c_st_mul_wet || r_state == c_st_mul_fb) && r_first) begin
            w_mul_start = 1'b1;
        end
        if (r_state == c_st_mul_fb) begin
            w_mul_coef = r_fb_gain;
        end
    end

    serial_signed_multiplier #(
        .MCAND_WIDTH (SAMPLE_WIDTH),
        .COEF_WIDTH  (COEF_WIDTH)
    ) u_multiplier (
        .clk            (clk),
        .reset          (reset),
        .i_start        (w_mul_start),
        .i_multiplicand (r_buffer),
        .i_coef         (w_mul_coef),
        .o_done         (w_mul_done),
        .o_product      (w_mul_product)
    );

    // Operand latches; the wet product is parked while the multiplier does feedback
    always_ff @(posedge clk) begin
        if (reset) begin
            r_current    <= '0;
            r_buffer     <= '0;
            r_wet_gain   <= '0;
            r_fb_gain    <= '0;
            r_wet_scaled <= '0;
        end else begin
            if (w_accept) begin
                r_current  <= i_current;
                r_buffer   <= i_buffer;
                r_wet_gain <= i_wet_gain;
                r_fb_gain  <= i_feedback_gain;
            end
            if (r_state == c_st_mul_fb && r_first) begin
                r_wet_scaled <= w_mul_product[PROD_WIDTH-1:COEF_WIDTH];
            end
        end
    end

    // Dropping the low COEF_WIDTH bits is the floor-toward-minus-infinity shift
    assign w_unused_product_bits = ^w_mul_product[COEF_WIDTH-1:0];
    assign w_wet_sum = {r_current[SAMPLE_WIDTH-1], r_current} + r_wet_scaled;
    assign w_fb_sum  = {r_current[SAMPLE_WIDTH-1], r_current} + w_mul_product[PROD_WIDTH-1:COEF_WIDTH];

    generate
        if (SAMPLE_WIDTH == ECHO_SAMPLE_WIDTH) begin : g_pkg_saturate
            assign w_wet_sat = echo_saturate(w_wet_sum);
            assign w_fb_sat  = echo_saturate(w_fb_sum);
        end else begin : g_local_saturate
            // Same clamp as the package helper, for non-default sample widths
            always_comb begin
                w_wet_sat = w_wet_sum[SAMPLE_WIDTH-1:0];
                w_fb_sat  = w_fb_sum[SAMPLE_WIDTH-1:0];
                if (w_wet_sum[SAMPLE_WIDTH] != w_wet_sum[SAMPLE_WIDTH-1]) begin
                    w_wet_sat = {w_wet_sum[SAMPLE_WIDTH], {(SAMPLE_WIDTH-1){~w_wet_sum[SAMPLE_WIDTH]}}};
                end
                if (w_fb_sum[SAMPLE_WIDTH] != w_fb_sum[SAMPLE_WIDTH-1]) begin
                    w_fb_sat = {w_fb_sum[SAMPLE_WIDTH], {(SAMPLE_WIDTH-1){~w_fb_sum[SAMPLE_WIDTH]}}};
                end
            end
        end
    endgenerate

    // Handshake flags follow the next state; results load in SUM and hold through OUT
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_out_current  <= '0;
            r_out_feedback <= '0;
        end else begin
            r_in_ready  <= (w_next_state == c_st_idle);
            r_out_valid <= (w_next_state == c_st_out);
            if (r_state == c_st_sum) begin
                r_out_current  <= w_wet_sat;
                r_out_feedback <= w_fb_sat;
            end
        end
    end

    assign i_ready    = r_in_ready;
    assign o_valid    = r_out_valid;
    assign o_current  = r_out_current;
    assign o_feedback = r_out_feedback;

endmodule
`default_nettype wire

// File: tb/tb_echo_feedback_processor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_echo_feedback_processor
//  Description : Scoreboard bench for echo_feedback_processor with directed,
//                hand-computed sample pairs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_echo_feedback_processor;

    localparam int LAT = 18;   // accept cycle to first o_valid cycle

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic        i_ready;
    logic [15:0] i_current;
    logic [15:0] i_buffer;
    logic [7:0]  i_wet_gain;
    logic [7:0]  i_feedback_gain;
    logic        o_valid;
    logic        o_ready;
    logic [15:0] o_current;
    logic [15:0] o_feedback;

    typedef struct {
        int    cur;
        int    fb;
        int    acc_cycle;
        string name;
    } exp_t;

    exp_t  sb[$];
    exp_t  mon_item;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cycle = 0;
    int    hs_cycle = -1;
    int    last_accept = -1;
    logic  prev_valid = 1'b0;

    echo_feedback_processor dut (
        .clk             (clk),
        .reset           (reset),
        .i_valid         (i_valid),
        .i_ready         (i_ready),
        .i_current       (i_current),
        .i_buffer        (i_buffer),
        .i_wet_gain      (i_wet_gain),
        .i_feedback_gain (i_feedback_gain),
        .o_valid         (o_valid),
        .o_ready         (o_ready),
        .o_current       (o_current),
        .o_feedback      (o_feedback)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Monitor: latency on o_valid rise, data on each output handshake
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (o_valid) check("i_ready_low_while_o_valid", i_ready, 0);
            if (o_valid && !prev_valid) begin
                if (sb.size() > 0) check({"latency_", sb[0].name}, cycle - sb[0].acc_cycle, LAT);
                else               check("unexpected_o_valid", o_valid, 0);
            end
            if (o_valid && o_ready) begin
                hs_cycle = cycle;
                if (sb.size() > 0) begin
                    mon_item = sb.pop_front();
                    check({"o_current_", mon_item.name},  $signed(o_current),  mon_item.cur);
                    check({"o_feedback_", mon_item.name}, $signed(o_feedback), mon_item.fb);
                end
            end
            prev_valid = o_valid;
        end
    end

    // Present one pair as soon as i_ready is seen; queue the expected result
    task automatic send(input int cur, input int buff, input int wg, input int fg,
                        input int exp_c, input int exp_f, input string name,
                        input bit expect_out);
        int waited = 0;
        @(negedge clk);
        while (!i_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!i_ready) begin
            check({"accept_timeout_", name}, i_ready, 1);
            return;
        end
        i_valid         = 1'b1;
        i_current       = cur[15:0];
        i_buffer        = buff[15:0];
        i_wet_gain      = wg[7:0];
        i_feedback_gain = fg[7:0];
        last_accept     = cycle;
        if (expect_out) sb.push_back('{cur: exp_c, fb: exp_f, acc_cycle: cycle, name: name});
        @(posedge clk);
        #1;
        i_valid         = 1'b0;
        i_current       = 16'($urandom);
        i_buffer        = 16'($urandom);
        i_wet_gain      = 8'($urandom);
        i_feedback_gain = 8'($urandom);
    endtask

    task automatic drain(input string name);
        int waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            check({"drain_timeout_", name}, sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        int seen;
        int waited;
        reset = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
        i_current = '0; i_buffer = '0; i_wet_gain = '0; i_feedback_gain = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_i_ready",    i_ready, 1);
        check("reset_o_valid",    o_valid, 0);
        check("reset_o_current",  $signed(o_current), 0);
        check("reset_o_feedback", $signed(o_feedback), 0);

        // Main function and boundaries
        send(1000,   2000,   128, 64,  2000,   1500,   "basic",   1);
        send(0,      -3,     128, 0,   -2,     0,      "floor",   1);
        send(32000,  32000,  255, 255, 32767,  32767,  "sat_pos", 1);
        send(-32768, -32768, 255, 255, -32768, -32768, "sat_neg", 1);
        send(-100,   1000,   255, 1,   896,    -97,    "mixed",   1);
        send(5,      -1,     1,   255, 4,      4,      "tiny",    1);
        drain("main");

        // Backpressure: results must hold while o_ready is low
        o_ready = 1'b0;
        send(300, -400, 200, 100, -13, 143, "bp", 1);
        waited = 0;
        while (!o_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("bp_o_valid_seen", o_valid, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_hold_o_valid",    o_valid, 1);
            check("bp_hold_o_current",  $signed(o_current), -13);
            check("bp_hold_o_feedback", $signed(o_feedback), 143);
            check("bp_hold_i_ready",    i_ready, 0);
            i_valid   = ~i_valid;
            i_current = 16'($urandom);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        o_ready = 1'b1;
        send(7, 100, 0, 0, 7, 7, "after_bp", 1);
        check("bp_next_accept_gap", last_accept - hs_cycle, 1);
        drain("bp");

        // Reset in the middle of the wet multiply aborts the pair
        send(1234, 1111, 77, 33, 0, 0, "abort", 0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_i_ready",    i_ready, 1);
        check("abort_o_valid",    o_valid, 0);
        check("abort_o_current",  $signed(o_current), 0);
        check("abort_o_feedback", $signed(o_feedback), 0);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        check("abort_no_o_valid", seen, 0);

        send(-5, -5, 128, 128, -8, -8, "recover", 1);
        drain("recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
